// File: rtl/sdram_arbiter.sv
// Time-slot arbiter sharing one SDRAM controller port between Z80 refresh, CPU and DMA.
// One command pulse per CYCLES-clock slot; fixed priority refresh > CPU > DMA.
module sdram_arbiter #(
   parameter int AW     = 18,
   parameter int CYCLES = 8,
   parameter int RDLAT  = 6
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          rfReq,
   input  logic          cpuRd,
   input  logic          cpuWr,
   input  logic [AW-1:0] cpuA,
   input  logic [7:0]    cpuD,
   output logic [7:0]    cpuQ,
   input  logic          dmaReq,
   input  logic          dmaWe,
   input  logic [AW-1:0] dmaA,
   input  logic [7:0]    dmaD,
   output logic [7:0]    dmaQ,
   output logic          dmaAck,
   output logic          sdrRf,
   output logic          sdrRd,
   output logic          sdrWr,
   output logic [23:0]   sdrA,
   output logic [15:0]   sdrD,
   input  logic [15:0]   sdrQ,
   output logic          busy
);

   localparam int CW = $clog2(CYCLES);

   typedef enum logic {S_IDLE, S_SLOT} state_t;
   typedef enum logic [1:0] {SRC_RF, SRC_CPU, SRC_DMA} src_t;

   state_t        r_state;
   src_t          r_src;
   logic          r_is_rd;
   logic [CW-1:0] r_cnt;
   logic          r_rf_pend;
   logic          r_cpu_pend;
   logic          r_cpu_we;
   logic [AW-1:0] r_cpu_a;
   logic [7:0]    r_cpu_d;
   logic          r_dma_req_q;
   logic          r_sdr_rf, r_sdr_rd, r_sdr_wr, r_dma_ack;
   logic [23:0]   r_sdr_a;
   logic [15:0]   r_sdr_d;
   logic [7:0]    r_cpu_q, r_dma_q;

   logic w_dma_ok, w_arb, w_issue;
   logic w_unused;

   // DMA is eligible once its level has been seen for a cycle, matching the strobe-to-pending delay.
   // The requester must present its next transfer or drop dmaReq within the ack cycle.
   assign w_dma_ok = r_dma_req_q & dmaReq;
   assign w_arb    = (r_state == S_IDLE) || (r_cnt == CW'(CYCLES - 1));
   assign w_issue  = w_arb & (r_rf_pend | r_cpu_pend | w_dma_ok);
   assign w_unused = &{1'b0, sdrQ[15:8]};

   // NOTE: plain input sampler with no reset; a request held through reset is seen on the first clock after it.
   always_ff @(posedge clock) r_dma_req_q <= dmaReq;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_src      <= SRC_RF;
         r_is_rd    <= 1'b0;
         r_cnt      <= '0;
         r_rf_pend  <= 1'b0;
         r_cpu_pend <= 1'b0;
         r_cpu_we   <= 1'b0;
         r_cpu_a    <= '0;
         r_cpu_d    <= '0;
         r_sdr_rf   <= 1'b0;
         r_sdr_rd   <= 1'b0;
         r_sdr_wr   <= 1'b0;
         r_dma_ack  <= 1'b0;
         r_sdr_a    <= '0;
         r_sdr_d    <= '0;
         r_cpu_q    <= '0;
         r_dma_q    <= '0;
      end else begin
         // NOTE: pulses default low here and are raised only by the branch that issues them.
         r_sdr_rf  <= 1'b0;
         r_sdr_rd  <= 1'b0;
         r_sdr_wr  <= 1'b0;
         r_dma_ack <= 1'b0;

         if (r_state == S_SLOT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_rd && r_cnt == CW'(RDLAT)) begin
               if (r_src == SRC_CPU) r_cpu_q <= sdrQ[7:0];
               else                  r_dma_q <= sdrQ[7:0];
            end
            if (r_src == SRC_DMA && r_cnt == CW'(CYCLES - 2)) r_dma_ack <= 1'b1;
         end

         if (w_arb) begin
            r_cnt <= '0;
            if (w_issue) begin
               r_state <= S_SLOT;
               if (r_rf_pend) begin
                  r_src     <= SRC_RF;
                  r_is_rd   <= 1'b0;
                  r_sdr_rf  <= 1'b1;
                  r_sdr_a   <= '0;
                  r_sdr_d   <= '0;
                  r_rf_pend <= 1'b0;
               end else if (r_cpu_pend) begin
                  r_src      <= SRC_CPU;
                  r_is_rd    <= ~r_cpu_we;
                  r_sdr_rd   <= ~r_cpu_we;
                  r_sdr_wr   <= r_cpu_we;
                  r_sdr_a    <= {{(24-AW){1'b0}}, r_cpu_a};
                  r_sdr_d    <= {2{r_cpu_d}};
                  r_cpu_pend <= 1'b0;
               end else begin
                  r_src    <= SRC_DMA;
                  r_is_rd  <= ~dmaWe;
                  r_sdr_rd <= ~dmaWe;
                  r_sdr_wr <= dmaWe;
                  r_sdr_a  <= {{(24-AW){1'b0}}, dmaA};
                  r_sdr_d  <= {2{dmaD}};
               end
            end else begin
               r_state <= S_IDLE;
            end
         end

         // New strobes come last so they win over the clear of a flag being issued this cycle.
         if (rfReq) r_rf_pend <= 1'b1;
         if (cpuRd | cpuWr) begin
            r_cpu_pend <= 1'b1;
            r_cpu_we   <= cpuWr;
            r_cpu_a    <= cpuA;
            r_cpu_d    <= cpuD;
         end
      end
   end

   assign sdrRf  = r_sdr_rf;
   assign sdrRd  = r_sdr_rd;
   assign sdrWr  = r_sdr_wr;
   assign sdrA   = r_sdr_a;
   assign sdrD   = r_sdr_d;
   assign dmaAck = r_dma_ack;
   assign cpuQ   = r_cpu_q;
   assign dmaQ   = r_dma_q;
   assign busy   = (r_state == S_SLOT);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: slot timing, priority, DMA streaming, strobe overwrite, reset abort.
module tb_sdram_arbiter;

   localparam int AW     = 18;
   localparam int CYCLES = 8;
   localparam int RDLAT  = 6;

   logic          clock, reset;
   logic          rfReq, cpuRd, cpuWr;
   logic [AW-1:0] cpuA;
   logic [7:0]    cpuD, cpuQ;
   logic          dmaReq, dmaWe;
   logic [AW-1:0] dmaA;
   logic [7:0]    dmaD, dmaQ;
   logic          dmaAck, sdrRf, sdrRd, sdrWr, busy;
   logic [23:0]   sdrA;
   logic [15:0]   sdrD, sdrQ;

   int checks = 0;
   int errors = 0;

   // Controller model: read data appears RDLAT cycles after the read command, garbage otherwise.
   int       rd_age = 15;
   logic [7:0] rd_data = 8'h00;
   assign sdrQ = (rd_age == RDLAT) ? {8'h33, rd_data} : 16'hDEAD;
   always @(negedge clock) begin
      if (sdrRd) rd_age = 0;
      else if (rd_age != 15) rd_age = rd_age + 1;
   end

   sdram_arbiter #(.AW(AW), .CYCLES(CYCLES), .RDLAT(RDLAT)) dut (
      .clock(clock), .reset(reset),
      .rfReq(rfReq), .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ),
      .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaA(dmaA), .dmaD(dmaD), .dmaQ(dmaQ), .dmaAck(dmaAck),
      .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ),
      .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({sdrRf, sdrRd, sdrWr, dmaAck, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 00000", {sdrRf, sdrRd, sdrWr, dmaAck, busy});
      end
      checks++;
      if ({sdrA, sdrD} !== 40'h0) begin
         errors++;
         $display("FAIL reset_addr got %h/%h exp 0/0", sdrA, sdrD);
      end
      checks++;
      if ({cpuQ, dmaQ} !== 16'h0) begin
         errors++;
         $display("FAIL reset_q got %h/%h exp 0/0", cpuQ, dmaQ);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_cpu_read();
      rd_data = 8'h5A;
      for (int c = 0; c <= 12; c++) begin
         cpuRd = (c == 0);
         cpuA  = 18'h0_4000;
         checks++;
         if (sdrRd !== (c == 2)) begin
            errors++;
            $display("FAIL cpu_rd_pulse c=%0d got %b exp %b", c, sdrRd, c == 2);
         end
         checks++;
         if (busy !== (c >= 2 && c <= 9)) begin
            errors++;
            $display("FAIL cpu_rd_busy c=%0d got %b exp %b", c, busy, c >= 2 && c <= 9);
         end
         checks++;
         if (cpuQ !== ((c >= 9) ? 8'h5A : 8'h00)) begin
            errors++;
            $display("FAIL cpu_rd_q c=%0d got %h exp %h", c, cpuQ, (c >= 9) ? 8'h5A : 8'h00);
         end
         if (c == 2) begin
            checks++;
            if (sdrA !== 24'h004000) begin
               errors++;
               $display("FAIL cpu_rd_addr got %h exp 004000", sdrA);
            end
         end
         tick();
      end
   endtask

   task automatic test_priority();
      rd_data = 8'hC3;
      for (int c = 0; c <= 27; c++) begin
         rfReq = (c == 0);
         cpuWr = (c == 0);
         cpuA  = 18'h1_2345;
         cpuD  = 8'hA5;
         dmaWe = 1'b0;
         dmaA  = 18'h0_0777;
         if (c == 0)  dmaReq = 1'b1;
         if (c == 25) dmaReq = 1'b0;
         checks++;
         if ({sdrRf, sdrWr, sdrRd, dmaAck} !== {c == 2, c == 10, c == 18, c == 25}) begin
            errors++;
            $display("FAIL prio_pulses c=%0d got rf/wr/rd/ack %b exp %b", c,
                     {sdrRf, sdrWr, sdrRd, dmaAck}, {c == 2, c == 10, c == 18, c == 25});
         end
         if (c == 2) begin
            checks++;
            if ({sdrA, sdrD} !== 40'h0) begin
               errors++;
               $display("FAIL prio_rf_addr got %h/%h exp 0/0", sdrA, sdrD);
            end
         end
         if (c == 10) begin
            checks++;
            if ({sdrA, sdrD} !== {24'h012345, 16'hA5A5}) begin
               errors++;
               $display("FAIL prio_wr_addr got %h/%h exp 012345/a5a5", sdrA, sdrD);
            end
         end
         if (c == 18) begin
            checks++;
            if (sdrA !== 24'h000777) begin
               errors++;
               $display("FAIL prio_dma_addr got %h exp 000777", sdrA);
            end
         end
         if (c == 25) begin
            checks++;
            if (dmaQ !== 8'hC3) begin
               errors++;
               $display("FAIL prio_dma_q got %h exp c3", dmaQ);
            end
            checks++;
            if (cpuQ !== 8'h5A) begin
               errors++;
               $display("FAIL prio_cpu_q_kept got %h exp 5a", cpuQ);
            end
         end
         tick();
      end
   endtask

   task automatic test_dma_stream();
      logic [AW-1:0] addr [3];
      logic [7:0]    data [3];
      int            k;
      addr[0] = 18'h2_0010; addr[1] = 18'h2_0011; addr[2] = 18'h3_FFFF;
      data[0] = 8'h11;      data[1] = 8'h22;      data[2] = 8'hEE;
      k = 0;
      dmaWe = 1'b1;
      for (int c = 0; c <= 28; c++) begin
         if (c == 0) dmaReq = 1'b1;
         if (c == 9 || c == 17) k++;
         if (c == 25) dmaReq = 1'b0;
         dmaA = addr[k];
         dmaD = data[k];
         checks++;
         if ({sdrWr, sdrRd, dmaAck} !== {c == 2 || c == 10 || c == 18, 1'b0, c == 9 || c == 17 || c == 25}) begin
            errors++;
            $display("FAIL dma_stream_pulses c=%0d got wr/rd/ack %b exp %b", c, {sdrWr, sdrRd, dmaAck},
                     {c == 2 || c == 10 || c == 18, 1'b0, c == 9 || c == 17 || c == 25});
         end
         checks++;
         if (busy !== (c >= 2 && c <= 25)) begin
            errors++;
            $display("FAIL dma_stream_busy c=%0d got %b exp %b", c, busy, c >= 2 && c <= 25);
         end
         if (c == 2 || c == 10 || c == 18) begin
            checks++;
            if ({sdrA, sdrD} !== {6'd0, addr[(c - 2) / 8], {2{data[(c - 2) / 8]}}}) begin
               errors++;
               $display("FAIL dma_stream_addr c=%0d got %h/%h exp %h/%h", c, sdrA, sdrD,
                        {6'd0, addr[(c - 2) / 8]}, {2{data[(c - 2) / 8]}});
            end
         end
         tick();
      end
   endtask

   task automatic test_collision();
      for (int c = 0; c <= 19; c++) begin
         rfReq = (c == 0);
         cpuRd = (c == 4);
         cpuWr = (c == 5);
         cpuA  = (c == 4) ? 18'h0_1111 : 18'h2_2222;
         cpuD  = 8'h3C;
         checks++;
         if ({sdrRf, sdrRd, sdrWr} !== {c == 2, 1'b0, c == 10}) begin
            errors++;
            $display("FAIL collide_pulses c=%0d got rf/rd/wr %b exp %b", c, {sdrRf, sdrRd, sdrWr},
                     {c == 2, 1'b0, c == 10});
         end
         if (c == 10) begin
            checks++;
            if ({sdrA, sdrD} !== {24'h022222, 16'h3C3C}) begin
               errors++;
               $display("FAIL collide_addr got %h/%h exp 022222/3c3c", sdrA, sdrD);
            end
         end
         tick();
      end
      checks++;
      if (cpuQ !== 8'h5A) begin
         errors++;
         $display("FAIL collide_cpu_q got %h exp 5a", cpuQ);
      end
   endtask

   task automatic test_reset_mid_slot();
      rd_data = 8'h96;
      dmaWe   = 1'b0;
      dmaA    = 18'h1_0ABC;
      for (int c = 0; c <= 17; c++) begin
         if (c == 0)  dmaReq = 1'b1;
         if (c == 14) dmaReq = 1'b0;
         cpuWr = (c == 3);
         cpuA  = 18'h0_0042;
         reset = (c == 5);
         checks++;
         if ({sdrRf, sdrRd, sdrWr, dmaAck} !== {1'b0, c == 2 || c == 7, 1'b0, c == 14}) begin
            errors++;
            $display("FAIL rst_mid_pulses c=%0d got rf/rd/wr/ack %b exp %b", c, {sdrRf, sdrRd, sdrWr, dmaAck},
                     {1'b0, c == 2 || c == 7, 1'b0, c == 14});
         end
         checks++;
         if (busy !== ((c >= 2 && c <= 5) || (c >= 7 && c <= 14))) begin
            errors++;
            $display("FAIL rst_mid_busy c=%0d got %b exp %b", c, busy, (c >= 2 && c <= 5) || (c >= 7 && c <= 14));
         end
         if (c == 6) begin
            checks++;
            if ({sdrA, sdrD, cpuQ, dmaQ} !== 56'h0) begin
               errors++;
               $display("FAIL rst_mid_zero got %h/%h/%h/%h exp all 0", sdrA, sdrD, cpuQ, dmaQ);
            end
         end
         if (c == 7) begin
            checks++;
            if (sdrA !== 24'h010ABC) begin
               errors++;
               $display("FAIL rst_mid_addr got %h exp 010abc", sdrA);
            end
         end
         if (c == 14) begin
            checks++;
            if (dmaQ !== 8'h96) begin
               errors++;
               $display("FAIL rst_mid_dma_q got %h exp 96", dmaQ);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      rd_data = 8'h11;
      for (int c = 0; c <= 19; c++) begin
         cpuRd = (c == 0 || c == 4);
         cpuA  = (c == 0) ? 18'h0_0100 : 18'h0_0200;
         if (c == 9) rd_data = 8'h22;
         checks++;
         if (sdrRd !== (c == 2 || c == 10)) begin
            errors++;
            $display("FAIL b2b_rd_pulse c=%0d got %b exp %b", c, sdrRd, c == 2 || c == 10);
         end
         if (c == 10) begin
            checks++;
            if (sdrA !== 24'h000200) begin
               errors++;
               $display("FAIL b2b_addr got %h exp 000200", sdrA);
            end
         end
         if (c == 9 || c == 16 || c == 17) begin
            checks++;
            if (cpuQ !== ((c == 17) ? 8'h22 : 8'h11)) begin
               errors++;
               $display("FAIL b2b_cpu_q c=%0d got %h exp %h", c, cpuQ, (c == 17) ? 8'h22 : 8'h11);
            end
         end
         tick();
      end
   endtask

   initial begin
      reset  = 1'b1;
      rfReq  = 1'b0;
      cpuRd  = 1'b0;
      cpuWr  = 1'b0;
      cpuA   = '0;
      cpuD   = '0;
      dmaReq = 1'b0;
      dmaWe  = 1'b0;
      dmaA   = '0;
      dmaD   = '0;
      tick();
      test_reset();
      test_cpu_read();
      test_priority();
      test_dma_stream();
      test_collision();
      test_reset_mid_slot();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sequences the single SDRAM controller port between three requesters: Z80 refresh, CPU memory port (rd/wr strobes from main), and a DMA port for the SD-card snapshot/tape loader.
- Sits between main/loader and the sdram block.
- Issues one single-cycle command per fixed-length slot, returns read data per requester, and fixes priority and back-pressure rules.

Parameters:
AW, 18, requester address width; sdrA = {(24-AW)'d0, addr}
CYCLES, 8, slot length in clocks from command pulse to next possible command (min 4)
RDLAT, 6, slot cycle index at which sdrQ is valid for reads (1..CYCLES-1)

Ports:
clock  in  1  system clock (56 MHz)
reset  in  1  synchronous, active-high reset
rfReq  in  1  refresh strobe, one-cycle pulse
cpuRd  in  1  CPU read strobe, one-cycle pulse
cpuWr  in  1  CPU write strobe, one-cycle pulse
cpuA  in  AW  CPU address, sampled with strobe
cpuD  in  8  CPU write data, sampled with strobe
cpuQ  out  8  CPU read data, held until next CPU read completes
dmaReq  in  1  DMA request level; A/D/We stable while high until dmaAck
dmaWe  in  1  1=write, 0=read
dmaA  in  AW  DMA address
dmaD  in  8  DMA write data
dmaQ  out  8  DMA read data, valid in dmaAck cycle, held after
dmaAck  out  1  one-cycle completion pulse
sdrRf  out  1  refresh command pulse
sdrRd  out  1  read command pulse
sdrWr  out  1  write command pulse
sdrA  out  24  command address
sdrD  out  16  write data {2{byte}}
sdrQ  in  16  controller read data; low byte used
busy  out  1  high while a slot is active

Behaviour:
- Reset (sync, active-high): state IDLE, slot counter 0, all pending flags clear. sdrRf/sdrRd/sdrWr/dmaAck/busy=0, sdrA=0, sdrD=0, cpuQ=0, dmaQ=0.
- Reset mid-slot aborts the slot. No ack or data update is issued. The SDRAM controller is not reset by this block.
- Pending latches (depth 1):
  - rfPend is set by rfReq.
  - cpuPend is set by cpuRd|cpuWr, which also captures cpuA, cpuD and the op.
  - cpuRd&cpuWr in the same cycle counts as a write.
  - A new CPU strobe while cpuPend is set overwrites it (last wins).
  - A strobe arriving while its own slot is running is re-latched as pending.
- States: IDLE, SLOT.
  - IDLE: if any pending or dmaReq, select a winner with fixed priority refresh > CPU > DMA. Register the single command pulse (sdrRf, sdrRd or sdrWr) for exactly one cycle together with sdrA/sdrD. Enter SLOT with counter=0 in that same cycle. Clear the winner's pending flag.
  - SLOT: the counter increments each clock and busy=1.
    - At counter==RDLAT on a read slot, capture sdrQ[7:0] into cpuQ or dmaQ; it is visible the next cycle.
    - At counter==CYCLES-1, arbitrate again. If there is a winner, issue its command the next cycle (counter=0), so commands are spaced exactly CYCLES clocks. Otherwise go to IDLE.
- Latency:
  - A strobe in cycle 0 gives pend in cycle 1 and a command pulse in cycle 2 when idle.
  - A CPU read gives cpuQ updated in cycle 2+RDLAT+1.
- DMA handshake:
  - dmaAck pulses for one cycle at counter==CYCLES-1 of a DMA slot. dmaQ is already valid in that cycle for reads.
  - If dmaReq is still high in the cycle after dmaAck, it is treated as a new transfer.
  - A dmaReq drop before ack is a protocol violation. The in-flight slot completes and the ack is still pulsed.
- Starvation: DMA is served only in slots where neither rfPend nor cpuPend is set. The CPU strobe rate (≤1 per 4 T-states at 3.5 MHz) guarantees DMA gaps.
- Refresh slots drive sdrA=0 and sdrD=0.
- Command outputs never overlap: at most one of sdrRf/sdrRd/sdrWr is high in any cycle.

Test Plan:
- CYCLES=8, RDLAT=6, CPU read: cpuRd pulse at cycle 0 with cpuA=18'h0_4000, sdrQ model returns 16'hxx5A.
  - sdrRd high in cycle 2 only, sdrA=24'h004000.
  - cpuQ=8'h5A from cycle 9.
  - busy high cycles 2-9.
- Simultaneous rfReq, cpuWr (A=18'h1_2345, D=8'hA5) and dmaReq (read):
  - sdrRf in cycle 2.
  - sdrWr in cycle 10 with sdrA=24'h012345, sdrD=16'hA5A5.
  - sdrRd for DMA in cycle 18; dmaAck in cycle 25 with dmaQ valid.
- DMA stream: dmaReq held high for 3 writes, requester updating A/D after each ack → three sdrWr pulses 8 cycles apart; three dmaAck pulses; no gaps.
- Strobe collision: cpuRd then cpuWr in consecutive cycles before the slot starts → only the write is issued (last wins); cpuQ unchanged.
- Reset asserted at counter==3 of a DMA read slot:
  - No dmaAck.
  - All outputs 0 next cycle; pendings cleared.
  - After release, dmaReq still high → new slot starts 1 cycle later.
- Strobe during own slot: cpuRd at counter==2 of a CPU read slot → second sdrRd exactly CYCLES clocks after the first.
